univ_ff_bank: RTL and testbench

Parametrised bank of WIDTH flip-flops that can each be run as D, T, JK or SR from a single registered mode, so one block replaces the fixed-function converter flip-flops. It adds a cascade option in T mode (synchronous binary counter with terminal-count output) and a sticky SR-invalid flag. It sits wherever the sequential library needs a configurable register or counter stage.

---
 rtl/uff_pkg.sv | 14 +
 rtl/uff_cell.sv | 42 ++++
 rtl/univ_ff_bank.sv | 85 ++++++++
 tb/tb_univ_ff_bank.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uff_pkg.sv
// Shared mode encoding for the universal flip-flop bank.
// Pure types/constants: no latency, no flow control.
package uff_pkg;

  localparam int UFF_MODE_W = 2;

  typedef enum logic [UFF_MODE_W-1:0] {
    UFF_D  = 2'd0,
    UFF_T  = 2'd1,
    UFF_JK = 2'd2,
    UFF_SR = 2'd3
  } uff_mode_t;

endpackage

// File: rtl/uff_cell.sv
// One bit of next-state logic for D/T/JK/SR; purely combinational, zero latency.
// No backpressure: the bank decides via en whether q_next is captured.
module uff_cell
  import uff_pkg::*;
(
  input  uff_mode_t mode,
  input  logic      a,
  input  logic      b,
  input  logic      q,
  input  logic      carry_in,
  output logic      q_next,
  output logic      invalid
);

  always_comb begin
    q_next  = q;
    invalid = 1'b0;
    case (mode)
      UFF_D:  q_next = a;
      UFF_T:  q_next = q ^ (a & carry_in);
      UFF_JK: begin
        case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      UFF_SR: begin
        // S=R=1 is illegal; the bit holds and the bank may record the event.
        case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   invalid = 1'b1;
          default: q_next = q;
        endcase
      end
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_ff_bank.sv
// Configurable D/T/JK/SR register bank with T-mode cascade counter; q updates one edge after en.
// No backpressure; optional sticky SR-invalid flag built when UFF_SR_ERR_EN is defined.
module univ_ff_bank
  import uff_pkg::*;
#(
  parameter int                    WIDTH     = 8,
  parameter logic [WIDTH-1:0]      INIT      = '0,
  parameter logic [UFF_MODE_W-1:0] INIT_MODE = 2'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [UFF_MODE_W-1:0] mode,
  input  logic                  mode_ld,
  input  logic                  en,
  input  logic                  cascade,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qn,
  output logic [UFF_MODE_W-1:0] cur_mode,
  output logic                  tc,
  output logic                  err
);

  logic [WIDTH-1:0] r_q;
  uff_mode_t        r_mode;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_invalid;

  // Bit i may toggle in cascade only when every lower bit is already 1.
  always_comb begin
    w_carry = '0;
    for (int i = 0; i < WIDTH; i++) begin
      logic [WIDTH-1:0] lo_mask;
      lo_mask    = {WIDTH{1'b1}} >> (WIDTH - i);
      w_carry[i] = ~cascade | ((r_q & lo_mask) == lo_mask);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    uff_cell u_cell (
      .mode     (r_mode),
      .a        (a[i]),
      .b        (b[i]),
      .q        (r_q[i]),
      .carry_in (w_carry[i]),
      .q_next   (w_q_next[i]),
      .invalid  (w_invalid[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= INIT;
      r_mode <= uff_mode_t'(INIT_MODE);
    end else begin
      if (en)      r_q    <= w_q_next;
      if (mode_ld) r_mode <= uff_mode_t'(mode);
    end
  end

  assign q        = r_q;
  assign qn       = ~r_q;
  assign cur_mode = r_mode;
  assign tc       = (r_mode == UFF_T) & cascade & en & (&a) & (&r_q);

`ifdef UFF_SR_ERR_EN
  logic r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_err <= 1'b0;
    else if (en && |w_invalid)  r_err <= 1'b1;
    else if (clr_err)           r_err <= 1'b0;
  end

  assign err = r_err;
`else
  logic w_unused;
  assign w_unused = clr_err ^ (|w_invalid);
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_univ_ff_bank.sv
// Directed bench for univ_ff_bank (WIDTH=8, INIT=8'hA5); err expectations follow UFF_SR_ERR_EN.
module tb_univ_ff_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       mode_ld;
  logic       en;
  logic       cascade;
  logic [7:0] a;
  logic [7:0] b;
  logic       clr_err;
  logic [7:0] q;
  logic [7:0] qn;
  logic [1:0] cur_mode;
  logic       tc;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef UFF_SR_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  univ_ff_bank #(.WIDTH(8), .INIT(8'hA5), .INIT_MODE(2'd0)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .mode_ld  (mode_ld),
    .en       (en),
    .cascade  (cascade),
    .a        (a),
    .b        (b),
    .clr_err  (clr_err),
    .q        (q),
    .qn       (qn),
    .cur_mode (cur_mode),
    .tc       (tc),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mode = 2'd0; mode_ld = 1'b0; en = 1'b0; cascade = 1'b0;
    a = 8'h00; b = 8'h00; clr_err = 1'b0;

    // Reset applied before any clock edge
    #2;
    check("rst_q",    q,        8'hA5);
    check("rst_qn",   qn,       8'h5A);
    check("rst_mode", cur_mode, 2'd0);
    check("rst_err",  err,      1'b0);
    check("rst_tc",   tc,       1'b0);
    @(negedge clk); reset = 1'b0;

    // D mode capture and hold
    en = 1'b1; a = 8'h3C;
    step();
    check("d_q",  q,  8'h3C);
    check("d_qn", qn, 8'hC3);
    en = 1'b0; a = 8'hFF;
    step();
    check("d_hold", q, 8'h3C);

    // Mode load: same edge still uses D
    mode = 2'd1; mode_ld = 1'b1; en = 1'b1; a = 8'hFF;
    step();
    check("sw_q_old_mode", q,        8'hFF);
    check("sw_cur_mode",   cur_mode, 2'd1);
    check("t_nocasc_tc",   tc,       1'b0);
    mode_ld = 1'b0;
    step();
    check("t_toggle", q, 8'h00);

    // Preload 0xFD via D then count in cascade
    mode = 2'd0; mode_ld = 1'b1; en = 1'b0;
    step();
    check("ld_d_mode", cur_mode, 2'd0);
    mode_ld = 1'b0; en = 1'b1; a = 8'hFD;
    step();
    check("ld_fd", q, 8'hFD);
    mode = 2'd1; mode_ld = 1'b1; en = 1'b0;
    step();
    mode_ld = 1'b0; en = 1'b1; cascade = 1'b1; a = 8'hFF;
    #1;
    check("cnt_tc_fd", tc, 1'b0);
    step();
    check("cnt_fe",    q,  8'hFE);
    check("cnt_tc_fe", tc, 1'b0);
    step();
    check("cnt_ff",    q,  8'hFF);
    check("cnt_tc_ff", tc, 1'b1);
    en = 1'b0;
    #1;
    check("cnt_tc_en0", tc, 1'b0);
    en = 1'b1;
    step();
    check("cnt_wrap",    q,  8'h00);
    check("cnt_tc_wrap", tc, 1'b0);
    step();
    check("cnt_01", q, 8'h01);
    a = 8'h0F;
    step();
    check("cnt_partial_a", q, 8'h02);
    a = 8'hFF;
    step(); step(); step();
    check("cnt_05", q, 8'h05);

    // Asynchronous reset mid-count
    #2; reset = 1'b1; #1;
    check("arst_q",    q,        8'hA5);
    check("arst_mode", cur_mode, 2'd0);
    @(negedge clk); reset = 1'b0; cascade = 1'b0;

    // JK
    en = 1'b1; a = 8'h0F;
    step();
    check("jk_pre", q, 8'h0F);
    mode = 2'd2; mode_ld = 1'b1; en = 1'b0;
    step();
    check("jk_mode", cur_mode, 2'd2);
    mode_ld = 1'b0; en = 1'b1; a = 8'hF0; b = 8'hFF;
    step();
    check("jk_tog_rst", q, 8'hF0);
    a = 8'h0C; b = 8'h30;
    step();
    check("jk_set_hold", q, 8'hCC);

    // SR and sticky err
    mode = 2'd0; mode_ld = 1'b1; en = 1'b0;
    step();
    mode_ld = 1'b0; en = 1'b1; a = 8'h00; b = 8'h00;
    step();
    check("sr_pre", q, 8'h00);
    mode = 2'd3; mode_ld = 1'b1; en = 1'b0;
    step();
    check("sr_mode",    cur_mode, 2'd3);
    check("sr_err_pre", err,      1'b0);
    mode_ld = 1'b0; en = 1'b1; a = 8'h81; b = 8'h01;
    step();
    check("sr_q_inv", q,   8'h80);
    check("sr_err",   err, ERR_ON);
    clr_err = 1'b1;
    step();
    check("sr_q_inv2",     q,   8'h80);
    check("sr_err_setwin", err, ERR_ON);
    a = 8'h00; b = 8'h80;
    step();
    check("sr_q_rst", q,   8'h00);
    check("sr_err_clr", err, 1'b0);
    clr_err = 1'b0; a = 8'h81; b = 8'h01; en = 1'b0;
    step();
    check("sr_en0_q",   q,   8'h00);
    check("sr_en0_err", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
